muldiv_unit: RTL and testbench

//  Multi-cycle multiply/divide unit in the execute stage, next to the ALU.
//  It takes the same register-file operands (a, b) as the ALU and handles

---
 rtl/muldiv_unit.sv | 140 ++++++++++++++
 tb/tb_muldiv_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with a final sign-correction cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [2*WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]       r_opb;
    logic                   r_is_div;
    logic                   r_dbz;
    logic                   r_neg_lo;
    logic                   r_neg_hi;

    logic                   w_accept;
    logic                   w_signed;
    logic                   w_b_zero;
    logic                   w_last;
    logic [WIDTH-1:0]       w_abs_a;
    logic [WIDTH-1:0]       w_abs_b;
    logic [WIDTH:0]         w_mul_sum;
    logic [WIDTH:0]         w_rem_sh;
    logic [WIDTH:0]         w_diff;
    logic                   w_q_bit;
    logic [WIDTH-1:0]       w_rem_next;
    logic [2*WIDTH-1:0]     w_result;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_signed = op[0];
    assign w_b_zero = (b == '0);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_abs_a  = (w_signed && a[WIDTH-1]) ? -a : a;
    assign w_abs_b  = (w_signed && b[WIDTH-1]) ? -b : b;
    assign busy     = (r_state != S_IDLE);

    // Multiply step: r_acc = {partial product high, multiplier shifting out}
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});

    // Divide step: r_acc = {partial remainder, dividend bits / quotient bits}
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff     = w_rem_sh - {1'b0, r_opb};
    assign w_q_bit    = ~w_diff[WIDTH];
    assign w_rem_next = w_q_bit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];

    always_comb begin
        w_result = r_acc;
        if (r_dbz) begin
            w_result = r_acc;
        end else if (r_is_div) begin
            w_result[2*WIDTH-1:WIDTH] = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
            w_result[WIDTH-1:0]       = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        end else if (r_neg_lo) begin
            w_result = -r_acc;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (!op[1])        w_next = S_MUL;
                    else if (w_b_zero) w_next = S_FIXUP;
                    else               w_next = S_DIV;
                end
            end
            S_MUL:   if (w_last) w_next = S_FIXUP;
            S_DIV:   if (w_last) w_next = S_FIXUP;
            S_FIXUP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            r_state <= w_next;
            done    <= (r_state == S_FIXUP);
            if (w_accept)
                r_cnt <= '0;
            else if (r_state == S_MUL || r_state == S_DIV)
                r_cnt <= r_cnt + 1'b1;
            if (r_state == S_FIXUP) begin
                div_by_zero <= r_dbz;
                hi          <= w_result[2*WIDTH-1:WIDTH];
                lo          <= w_result[WIDTH-1:0];
            end
        end
    end

    // Operand/accumulator path carries no reset; it is always reloaded on accept
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_is_div <= op[1];
            r_dbz    <= op[1] && w_b_zero;
            r_neg_lo <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_hi <= w_signed && a[WIDTH-1];
            if (!op[1]) begin
                r_acc <= {{WIDTH{1'b0}}, w_abs_b};
                r_opb <= w_abs_a;
            end else if (w_b_zero) begin
                r_acc <= {a, {WIDTH{1'b1}}};
                r_opb <= w_abs_b;
            end else begin
                r_acc <= {{WIDTH{1'b0}}, w_abs_a};
                r_opb <= w_abs_b;
            end
        end else if (r_state == S_MUL) begin
            r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
        end else if (r_state == S_DIV) begin
            r_acc <= {w_rem_next, r_acc[WIDTH-2:0], w_q_bit};
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, multi-cycle corner sequences,
// and random operations checked against a plain-arithmetic reference model.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b;
        logic [W-1:0] hi, lo;
        logic         z;
        int           lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [1:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  output logic [W-1:0] mhi, output logic [W-1:0] mlo, output logic mz);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        mz = 1'b0;
        case (mop)
            2'b00: begin p = {32'b0, ma} * {32'b0, mb}; mhi = p[63:32]; mlo = p[31:0]; end
            2'b01: begin p = sa * sb; mhi = p[63:32]; mlo = p[31:0]; end
            default: begin
                if (mb == 0) begin
                    mhi = ma; mlo = '1; mz = 1'b1;
                end else if (mop == 2'b10) begin
                    mlo = ma / mb; mhi = ma % mb;
                end else begin
                    p = sa / sb; mlo = p[31:0];
                    p = sa % sb; mhi = p[31:0];
                end
            end
        endcase
    endfunction

    // Starts an op (caller is #1 past an edge), returns edges after E0 until done.
    // At latency step glitch_at a DIVU 9/3 start pulse is driven while busy.
    task automatic run_op(input string name, input logic [1:0] top, input logic [W-1:0] ta,
                          input logic [W-1:0] tb, input int glitch_at, output int lat);
        logic [W-1:0] h0, l0;
        logic held, busy_ok;
        h0 = hi; l0 = lo; held = 1'b1; busy_ok = 1'b1;
        start = 1'b1; op = top; a = ta; b = tb;
        @(posedge clk); #1;
        lat = 0;
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            if (hi !== h0 || lo !== l0) held = 1'b0;
            if (lat == glitch_at) begin
                start = 1'b1; op = 2'b10; a = 9; b = 3;
            end else begin
                start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk({name, " done_seen"}, 64'(done), 64'd1);
        chk({name, " busy_during"}, 64'(busy_ok), 64'd1);
        chk({name, " hold_no_partial"}, 64'(held), 64'd1);
        chk({name, " busy_after"}, 64'(busy), 64'd0);
    endtask

    vec_t vecs[$];

    initial begin
        int lat;
        logic [W-1:0] ehi, elo;
        logic ez, never_done;

        vecs.push_back('{2'b00, 32'd5,        32'd7,        32'd0,        32'd35,       1'b0, 33});
        vecs.push_back('{2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33});
        vecs.push_back('{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0, 33});
        vecs.push_back('{2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33});
        vecs.push_back('{2'b10, 32'd7,        32'd2,        32'd1,        32'd3,        1'b0, 33});
        vecs.push_back('{2'b10, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, 1'b1, 1});
        vecs.push_back('{2'b00, 32'd2,        32'd2,        32'd0,        32'd4,        1'b0, 33});
        vecs.push_back('{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 33});
        vecs.push_back('{2'b11, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, 1});
        vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h1,        1'b0, 33});
        vecs.push_back('{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1,        1'b0, 33});
        vecs.push_back('{2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33});

        reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        #12;
        chk("reset busy", 64'(busy), 0);
        chk("reset done", 64'(done), 0);
        chk("reset dbz", 64'(div_by_zero), 0);
        chk("reset hi", 64'(hi), 0);
        chk("reset lo", 64'(lo), 0);
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, -1, lat);
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("vec%0d hi", i), 64'(hi), 64'(vecs[i].hi));
            chk($sformatf("vec%0d lo", i), 64'(lo), 64'(vecs[i].lo));
            chk($sformatf("vec%0d dbz", i), 64'(div_by_zero), 64'(vecs[i].z));
            @(posedge clk); #1;
            chk($sformatf("vec%0d done_pulse_one_cycle", i), 64'(done), 0);
        end

        // Start while busy is ignored; start in the done cycle is accepted
        run_op("ignore_busy", 2'b00, 32'd5, 32'd7, 10, lat);
        chk("ignore_busy latency", 64'(lat), 33);
        chk("ignore_busy lo", 64'(lo), 35);
        chk("ignore_busy hi", 64'(hi), 0);
        run_op("done_cycle_start", 2'b10, 32'd9, 32'd3, -1, lat);
        chk("done_cycle_start latency", 64'(lat), 33);
        chk("done_cycle_start lo", 64'(lo), 3);
        chk("done_cycle_start hi", 64'(hi), 0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a divide
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (15) @(posedge clk);
        #1; reset = 1'b0; #2;
        chk("midreset busy", 64'(busy), 0);
        chk("midreset hi", 64'(hi), 0);
        chk("midreset lo", 64'(lo), 0);
        chk("midreset done", 64'(done), 0);
        reset = 1'b1;
        never_done = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) never_done = 1'b0;
        end
        chk("midreset quiet", 64'(never_done), 1);
        run_op("after_reset", 2'b00, 32'd6, 32'd7, -1, lat);
        chk("after_reset lo", 64'(lo), 42);
        chk("after_reset hi", 64'(hi), 0);

        // Random operations against the reference model
        for (int k = 0; k < 40; k++) begin
            logic [1:0]   rop;
            logic [W-1:0] ra, rb;
            rop = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: ra = 32'h80000000;
                2: rb = 32'hFFFFFFFF;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            model(rop, ra, rb, ehi, elo, ez);
            run_op($sformatf("rnd%0d", k), rop, ra, rb, -1, lat);
            chk($sformatf("rnd%0d latency", k), 64'(lat), (rop[1] && rb == 0) ? 64'd1 : 64'd33);
            chk($sformatf("rnd%0d hi", k), 64'(hi), 64'(ehi));
            chk($sformatf("rnd%0d lo", k), 64'(lo), 64'(elo));
            chk($sformatf("rnd%0d dbz", k), 64'(div_by_zero), 64'(ez));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
